// File: rtl/vip_frame_capture.sv
// vip_frame_capture: single-frame capture sink for a 1-bit video stream.
// After a cap_start pulse it waits for the next frame start. It then packs
// accepted pixels MSB-first into PACK_W-bit words and writes them out through
// a simple synchronous RAM write port. Line and frame geometry are checked
// against IMG_HDISP x IMG_VDISP.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cap_start                pulse that arms a capture (accepted only when idle)
//   cap_busy / cap_done      capture in progress / one-cycle end-of-capture pulse
//   frame_err                sticky geometry error of the last capture
//   per_frame_vsync/href/clken, per_img_bit   incoming video stream
//   wr_en, wr_addr, wr_data  RAM write port (one pulse per packed word)
//   line_cnt                 completed lines in the current/last capture
module vip_frame_capture #(
    parameter int unsigned IMG_HDISP = 640,
    parameter int unsigned IMG_VDISP = 480,
    parameter int unsigned PACK_W    = 8,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_start,
    output logic              cap_busy,
    output logic              cap_done,
    output logic              frame_err,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic              per_img_bit,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PACK_W-1:0] wr_data,
    output logic [10:0]       line_cnt
);

    localparam int unsigned COL_W   = $clog2(IMG_HDISP + 1);
    localparam int unsigned BIT_W   = $clog2(PACK_W + 1);
    localparam int unsigned LINE_W  = 11;
    localparam int unsigned WCNT_W  = ADDR_W + 1;
    localparam int unsigned N_WORDS = (IMG_HDISP * IMG_VDISP) / PACK_W;
    localparam logic [LINE_W-1:0] LINE_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic              vsync_d, href_d;
    logic              vs_rise, vs_fall, hs_fall, pix_acc, start_acc;

    logic [COL_W-1:0]  col_cnt, col_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [PACK_W-2:0] shreg, sh_nxt;
    logic [PACK_W-1:0] sh_word;
    logic [WCNT_W-1:0] word_cnt, word_nxt;
    logic [LINE_W-1:0] line_nxt;
    logic              err_nxt, wr_en_nxt, busy_nxt, done_nxt;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [PACK_W-1:0] wr_data_nxt;

    // Edge detection against the one-stage delayed sync inputs
    assign vs_rise   = per_frame_vsync & ~vsync_d;
    assign vs_fall   = ~per_frame_vsync & vsync_d;
    assign hs_fall   = ~per_frame_href & href_d;
    assign pix_acc   = (state == S_CAPTURE) & per_frame_href & per_frame_clken & per_frame_vsync;
    assign start_acc = (state == S_IDLE) & cap_start;
    // Pixels held so far plus the incoming one, first pixel in the MSB
    assign sh_word   = {shreg, per_img_bit};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (cap_start) state_nxt = S_ARMED;
            S_ARMED:   if (vs_rise)   state_nxt = S_CAPTURE;
            S_CAPTURE: if (vs_fall)   state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        col_nxt     = col_cnt;
        bit_nxt     = bit_cnt;
        sh_nxt      = shreg;
        word_nxt    = word_cnt;
        line_nxt    = line_cnt;
        err_nxt     = frame_err;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        done_nxt    = (state_nxt == S_DONE);
        busy_nxt    = (state_nxt == S_ARMED) || (state_nxt == S_CAPTURE);

        if (start_acc) begin
            col_nxt     = '0;
            bit_nxt     = '0;
            sh_nxt      = '0;
            word_nxt    = '0;
            line_nxt    = '0;
            err_nxt     = 1'b0;
            wr_addr_nxt = '0;
        end else if (state == S_CAPTURE) begin
            if (pix_acc) begin
                // Extra lines and pixels past the line width are dropped
                if ((line_cnt >= LINE_W'(IMG_VDISP)) || (col_cnt == COL_W'(IMG_HDISP))) begin
                    err_nxt = 1'b1;
                end else begin
                    col_nxt = col_cnt + COL_W'(1);
                    if (bit_cnt == BIT_W'(PACK_W - 1)) begin
                        bit_nxt = '0;
                        sh_nxt  = '0;
                        if (word_cnt < WCNT_W'(N_WORDS)) begin
                            wr_en_nxt   = 1'b1;
                            wr_data_nxt = sh_word;
                            wr_addr_nxt = ADDR_W'(word_cnt);
                            word_nxt    = word_cnt + WCNT_W'(1);
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else begin
                        bit_nxt = bit_cnt + BIT_W'(1);
                        sh_nxt  = sh_word[PACK_W-2:0];
                    end
                end
            end

            // Line end: a short line's partial word is thrown away
            if (hs_fall) begin
                if (col_cnt != COL_W'(IMG_HDISP)) err_nxt = 1'b1;
                col_nxt = '0;
                bit_nxt = '0;
                sh_nxt  = '0;
                if (line_cnt != LINE_MAX) line_nxt = line_cnt + LINE_W'(1);
            end

            // Frame end sees the line count already updated by a coincident line end
            if (vs_fall) begin
                if (line_nxt != LINE_W'(IMG_VDISP)) err_nxt = 1'b1;
                if (per_frame_href) err_nxt = 1'b1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d   <= 1'b0;
            href_d    <= 1'b0;
            col_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            word_cnt  <= '0;
            line_cnt  <= '0;
            frame_err <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cap_busy  <= 1'b0;
            cap_done  <= 1'b0;
        end else begin
            vsync_d   <= per_frame_vsync;
            href_d    <= per_frame_href;
            col_cnt   <= col_nxt;
            bit_cnt   <= bit_nxt;
            shreg     <= sh_nxt;
            word_cnt  <= word_nxt;
            line_cnt  <= line_nxt;
            frame_err <= err_nxt;
            wr_en     <= wr_en_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
            cap_busy  <= busy_nxt;
            cap_done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_vip_frame_capture.sv
// Directed testbench for vip_frame_capture with a 16x4 frame and 8-pixel words.
module tb_vip_frame_capture;

    localparam int unsigned HD = 16;
    localparam int unsigned VD = 4;
    localparam int unsigned PW = 8;
    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cap_start = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic          clken = 1'b0;
    logic          pbit = 1'b0;
    logic          cap_busy, cap_done, frame_err, wr_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_data;
    logic [10:0]   line_cnt;

    vip_frame_capture #(
        .IMG_HDISP(HD),
        .IMG_VDISP(VD),
        .PACK_W   (PW),
        .ADDR_W   (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cap_start      (cap_start),
        .cap_busy       (cap_busy),
        .cap_done       (cap_done),
        .frame_err      (frame_err),
        .per_frame_vsync(vsync),
        .per_frame_href (href),
        .per_frame_clken(clken),
        .per_img_bit    (pbit),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .line_cnt       (line_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int vs_fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write and done monitor, sampled on the falling edge
    logic [AW-1:0] w_addr [0:255];
    logic [PW-1:0] w_data [0:255];
    int            wr_cnt = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    logic          done_err = 1'b0;
    logic          done_busy = 1'b0;
    logic [10:0]   done_line = '0;

    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_cnt < 256) begin
                w_addr[wr_cnt] <= wr_addr;
                w_data[wr_cnt] <= wr_data;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (cap_done) begin
            done_cnt  <= done_cnt + 1;
            done_cyc  <= cyc;
            done_err  <= frame_err;
            done_busy <= cap_busy;
            done_line <= line_cnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        cap_start = 1'b1;
        tick();
        cap_start = 1'b0;
    endtask

    // One frame of alternating 1,0 pixels. short_line gets HD-1 pixels,
    // arm_line pulses cap_start on its first pixel, abort_w asserts reset
    // once the monitor has seen that many writes in total.
    task automatic send_frame(input int nlines, input int short_line, input bit gaps,
                              input int arm_line, input int abort_w, output bit aborted);
        aborted = 1'b0;
        vsync = 1'b0; href = 1'b0; clken = 1'b0;
        repeat (4) tick();
        vsync = 1'b1;
        repeat (3) tick();
        for (int l = 0; l < nlines; l++) begin
            int npix;
            npix = (l == short_line) ? HD - 1 : HD;
            for (int j = 0; j < npix; j++) begin
                int g;
                g = 0;
                if (gaps) g = (j % 3 == 0) ? 1 : ((j % 5 == 1) ? 2 : 0);
                for (int k = 0; k < g; k++) begin
                    href = 1'b1; clken = 1'b0; pbit = (j % 2 != 0);
                    tick();
                end
                href = 1'b1; clken = 1'b1; pbit = (j % 2 == 0);
                cap_start = (l == arm_line) && (j == 0);
                tick();
                cap_start = 1'b0;
                if (abort_w > 0 && wr_cnt >= abort_w) begin
                    rst_n = 1'b0;
                    vsync = 1'b0; href = 1'b0; clken = 1'b0;
                    aborted = 1'b1;
                    return;
                end
            end
            href = 1'b0; clken = 1'b0; pbit = 1'b0;
            repeat (3) tick();
        end
        vsync = 1'b0;
        vs_fall_cyc = cyc;
        tick();
        tick();
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({cap_busy, cap_done, frame_err, wr_en} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000", {cap_busy, cap_done, frame_err, wr_en});
        end
        checks++;
        if (wr_addr !== 16'h0 || wr_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_wr got addr=%h data=%h exp 0/0", wr_addr, wr_data);
        end
        checks++;
        if (line_cnt !== 11'd0) begin
            failures++;
            $display("FAIL reset_line got=%0d exp=0", line_cnt);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (cap_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy got=%b exp=0", cap_busy);
        end
    endtask

    // Nominal 16x4 frame: 8 words of AA at addresses 0..7, no error
    task automatic test_frame(input string name, input bit gaps);
        int wb, db;
        bit ab, ok;
        wb = wr_cnt;
        db = done_cnt;
        arm();
        checks++;
        if (cap_busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy got=%b exp=1", name, cap_busy);
        end
        send_frame(VD, -1, gaps, -1, 0, ab);
        wait_done(db, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_done got=no cap_done exp=cap_done", name);
        end
        checks++;
        if (wr_cnt - wb !== 8) begin
            failures++;
            $display("FAIL %s_wcount got=%0d exp=8", name, wr_cnt - wb);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (w_addr[wb + k] !== 16'(k) || w_data[wb + k] !== 8'hAA) begin
                failures++;
                $display("FAIL %s_word%0d got addr=%0d data=%h exp addr=%0d data=aa",
                         name, k, w_addr[wb + k], w_data[wb + k], k);
            end
        end
        checks++;
        if (done_cyc !== vs_fall_cyc + 1) begin
            failures++;
            $display("FAIL %s_done_cycle got=%0d exp=%0d", name, done_cyc, vs_fall_cyc + 1);
        end
        checks++;
        if (done_err !== 1'b0 || done_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_flags got err=%b busy=%b exp err=0 busy=0", name, done_err, done_busy);
        end
        checks++;
        if (done_line !== 11'd4) begin
            failures++;
            $display("FAIL %s_lines got=%0d exp=4", name, done_line);
        end
        checks++;
        if (cap_done !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL %s_after got done=%b err=%b exp 0/0", name, cap_done, frame_err);
        end
    endtask

    // Armed while line 2 streams: nothing until the next frame start
    task automatic test_mid_arm();
        int wb, db;
        bit ab, ok;
        wb = wr_cnt;
        db = done_cnt;
        send_frame(VD, -1, 1'b0, 2, 0, ab);
        checks++;
        if (wr_cnt !== wb || done_cnt !== db || cap_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_arm_skip got writes=%0d dones=%0d busy=%b exp 0/0/1",
                     wr_cnt - wb, done_cnt - db, cap_busy);
        end
        send_frame(VD, -1, 1'b0, -1, 0, ab);
        wait_done(db, ok);
        checks++;
        if (!ok || wr_cnt - wb !== 8) begin
            failures++;
            $display("FAIL mid_arm_frame got done=%b writes=%0d exp 1/8", ok, wr_cnt - wb);
        end
        checks++;
        if (w_addr[wb] !== 16'd0 || w_addr[wb + 7] !== 16'd7 || w_data[wb + 7] !== 8'hAA) begin
            failures++;
            $display("FAIL mid_arm_addr got first=%0d last=%0d data=%h exp 0/7/aa",
                     w_addr[wb], w_addr[wb + 7], w_data[wb + 7]);
        end
        checks++;
        if (done_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_arm_err got=%b exp=0", done_err);
        end
    endtask

    // Line 1 one pixel short: partial word dropped, error flagged
    task automatic test_short_line();
        int wb, db;
        bit ab, ok;
        wb = wr_cnt;
        db = done_cnt;
        arm();
        send_frame(VD, 1, 1'b0, -1, 0, ab);
        wait_done(db, ok);
        checks++;
        if (!ok || wr_cnt - wb !== 7) begin
            failures++;
            $display("FAIL short_count got done=%b writes=%0d exp 1/7", ok, wr_cnt - wb);
        end
        checks++;
        if (w_addr[wb + 6] !== 16'd6 || w_data[wb + 6] !== 8'hAA) begin
            failures++;
            $display("FAIL short_last got addr=%0d data=%h exp 6/aa", w_addr[wb + 6], w_data[wb + 6]);
        end
        checks++;
        if (done_err !== 1'b1 || done_line !== 11'd4) begin
            failures++;
            $display("FAIL short_err got err=%b lines=%0d exp 1/4", done_err, done_line);
        end
    endtask

    // Five lines: the fifth is dropped, error flagged
    task automatic test_extra_line();
        int wb, db;
        bit ab, ok;
        wb = wr_cnt;
        db = done_cnt;
        arm();
        send_frame(VD + 1, -1, 1'b0, -1, 0, ab);
        wait_done(db, ok);
        checks++;
        if (!ok || wr_cnt - wb !== 8) begin
            failures++;
            $display("FAIL extra_count got done=%b writes=%0d exp 1/8", ok, wr_cnt - wb);
        end
        checks++;
        if (w_addr[wb + 7] !== 16'd7) begin
            failures++;
            $display("FAIL extra_last got addr=%0d exp=7", w_addr[wb + 7]);
        end
        checks++;
        if (done_err !== 1'b1 || done_line !== 11'd5) begin
            failures++;
            $display("FAIL extra_err got err=%b lines=%0d exp 1/5", done_err, done_line);
        end
    endtask

    // Reset after three writes abandons the frame silently
    task automatic test_reset_mid();
        int wb, db;
        bit ab;
        wb = wr_cnt;
        db = done_cnt;
        arm();
        send_frame(VD, -1, 1'b0, -1, wb + 3, ab);
        checks++;
        if (ab !== 1'b1) begin
            failures++;
            $display("FAIL rmid_abort got=no abort exp=abort after 3 writes");
        end
        #1;
        checks++;
        if ({cap_busy, cap_done, frame_err, wr_en, wr_addr, wr_data, line_cnt} !== '0) begin
            failures++;
            $display("FAIL rmid_outputs got busy=%b done=%b err=%b wen=%b addr=%0d data=%h lines=%0d exp all 0",
                     cap_busy, cap_done, frame_err, wr_en, wr_addr, wr_data, line_cnt);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        checks++;
        if (done_cnt !== db) begin
            failures++;
            $display("FAIL rmid_nodone got=%0d exp=0", done_cnt - db);
        end
        test_frame("after_reset", 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_frame("nominal", 1'b0);
        test_mid_arm();
        test_short_line();
        test_frame("gaps", 1'b1);
        test_extra_line();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
